bcd_seven_seg_scanner: RTL and testbench
========================================

Name: bcd_seven_seg_scanner

Overview:
- Downstream consumer of the BCD converter stage. Accepts 16-bit packed BCD tokens (4 digits: thousands, hundreds, tens, ones) over a valid/ready handshake.
- Time-multiplexes the 4 digits onto a common-anode-style 7-segment display: one digit per refresh slot.
- New tokens take effect only at a scan-frame boundary, so a frame never mixes two values.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit; legal range ≥2.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs driven low to light.
- ANODE_ACTIVE_LOW, 1, 1 = digit-enable outputs driven low to enable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bcd_number  in  16  packed BCD token: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- bcd_valid  in  1  bcd_number holds a token.
- bcd_ready  out  1  block can accept a token this cycle.
- seg  out  7  segment drive; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point; always off.
- anode  out  4  digit enable; anode[0]=ones … anode[3]=thousands.
- digit_error  out  1  displayed token contains a nibble greater than 9.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values and reset action:
  - seg, dp and anode are at their "off" level (with default parameters: seg=7'h7F, dp=1, anode=4'hF).
  - bcd_ready=1, digit_error=0.
  - pending_full=0, display_reg=0, prescaler=0, digit_idx=0, state=IDLE.
  - Reset asserted mid-operation discards any pending or displayed token the same edge.
- Handshake:
  - Acceptance occurs on an edge where bcd_valid && bcd_ready. bcd_number is latched into the pending register and pending_full is set.
  - bcd_ready = !pending_full (registered-state combinational). Exactly one token of buffering.
  - bcd_number is ignored when bcd_valid=0.
- State IDLE: outputs off, prescaler held at 0. When pending_full=1 at an edge:
  - pending moves to display_reg and pending_full clears;
  - digit_error <= any display nibble >9;
  - state -> SCAN, digit_idx=0, prescaler=0.
- State SCAN:
  - prescaler counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge, digit_idx increments modulo 4 (3 -> 0).
  - Frame boundary is the wrap edge with digit_idx==3. If pending_full=1 at that edge, the pending-to-display transfer above occurs in the same edge as digit_idx returns to 0.
  - SCAN never returns to IDLE except through reset.
- Simultaneous events: a token accepted on the frame-boundary edge is not transferred on that edge, because the transfer samples the pre-edge pending_full. It waits for the next frame boundary.
- Outputs are registered from (display_reg, digit_idx): they reflect a new digit_idx one cycle after it changes.
  - Latency from acceptance in IDLE: the accept edge is E0, the transfer is E1, and the first digit appears after E2.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- anode: exactly one bit active (the digit_idx bit); all others off.
- Decoding, active-high gfedcba form:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A–F are shown as a dash, 40.
  - seg = SEG_ACTIVE_LOW ? ~pattern : pattern. anode is inverted likewise per ANODE_ACTIVE_LOW.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during the slot of digit k (k = 3, 2, 1), anode stays off when nibble k and all higher nibbles are 0. The ones digit is never blanked, so 0x0000 displays a single "0". Scan timing is unchanged: blanked slots still last REFRESH_DIV cycles.
- Undefined: all 4 digits are always enabled in their slots.

Test Plan (REFRESH_DIV=4, default active-low):
1. Hold reset 3 cycles -> seg=7'h7F, anode=4'hF, dp=1, bcd_ready=1, digit_error=0.
2. Send 16'h1234 with valid for 1 cycle after reset -> bcd_ready=0 for 1 cycle. 2 edges later: anode=4'b1110, seg=7'h19 for 4 cycles. Then anode=4'b1101, seg=7'h30, then 4'b1011/seg 7'h24, then 4'b0111/seg 7'h79, then repeat.
3. While 0x1234 is scanning, send 0x0001 mid-frame, then hold 0x0002 valid -> 0x0001 accepted and bcd_ready=0 until the frame boundary. The display switches to 0x0001 only when the ones digit next appears. 0x0002 is accepted on that boundary edge and shown one frame later.
4. Send 16'h12A4 -> tens slot shows seg=7'h3F (dash); digit_error=1. Then send 16'h5678 -> digit_error=0 after its transfer.
5. With LEADING_ZERO_BLANK_EN, send 16'h0007 -> the ones slot shows seg=7'h78; the slots for digits 3..1 keep anode=4'hF. Send 16'h0000 -> only the ones slot lit, showing seg=7'h40. Without the macro, 16'h0007 lights all 4 digits.
6. Assert reset for 1 cycle mid-scan with pending_full=1 -> the next cycle has outputs off, bcd_ready=1, state IDLE. The pending token is never displayed.

Source files
------------

// File: rtl/bcd_seven_seg_scanner.sv
// rtl/bcd_seven_seg_scanner.sv - 4-digit packed-BCD token scanner for a multiplexed 7-segment display
//
// Purpose:
//   Accepts 16-bit packed BCD tokens over a valid/ready handshake, holds one token of
//   buffering, and time-multiplexes the four digits onto a common-anode-style display.
//   A new token is only swapped in at a scan-frame boundary so a frame never mixes values.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   Defined   - leading zero digits (thousands/hundreds/tens) keep their anode off;
//               the ones digit is always lit. Slot timing is unchanged.
//   Undefined - every digit is enabled in its slot.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   bcd_number   in   [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
//   bcd_valid    in   bcd_number holds a token
//   bcd_ready    out  a token can be accepted this cycle
//   seg          out  segment drive, seg[0]=a .. seg[6]=g
//   dp           out  decimal point, always off
//   anode        out  digit enable, anode[0]=ones .. anode[3]=thousands
//   digit_error  out  displayed token contains a nibble greater than 9

module bcd_seven_seg_scanner #(
  parameter int REFRESH_DIV      = 50000,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_number,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  anode,
  output logic        digit_error
);

  localparam int              PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [3:0]      AN_OFF   = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     pending_q, pending_d;
  logic            pending_full_q, pending_full_d;
  logic [15:0]     display_q, display_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic [1:0]      digit_idx_q, digit_idx_d;
  logic            digit_error_q, digit_error_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      anode_q, anode_d;

  logic            accept;
  logic            load;
  logic            wrap;
  logic [3:0]      nibble;
  logic [6:0]      pattern;
  logic [3:0]      onehot;

  // Active-high gfedcba pattern; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_pattern(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic has_bad_nibble(input logic [15:0] d);
    return (d[15:12] > 4'd9) || (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
  endfunction

  assign bcd_ready = !pending_full_q;

  // Next-state: handshake, frame sequencing and pending-to-display transfer.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    display_d      = display_q;
    prescaler_d    = prescaler_q;
    digit_idx_d    = digit_idx_q;
    digit_error_d  = digit_error_q;
    load           = 1'b0;
    accept         = bcd_valid && !pending_full_q;
    wrap           = (prescaler_q == PRE_LAST);

    case (state_q)
      IDLE: begin
        prescaler_d = '0;
        digit_idx_d = '0;
        if (pending_full_q) begin
          load    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (wrap) begin
          prescaler_d = '0;
          digit_idx_d = digit_idx_q + 2'd1;
          // Frame boundary: the last slot is ending and the index returns to 0.
          if (digit_idx_q == 2'd3 && pending_full_q) begin
            load = 1'b1;
          end
        end else begin
          prescaler_d = prescaler_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      display_d     = pending_q;
      digit_error_d = has_bad_nibble(pending_q);
    end

    // accept needs an empty buffer and load needs a full one, so they never coincide.
    if (accept) begin
      pending_d      = bcd_number;
      pending_full_d = 1'b1;
    end else if (load) begin
      pending_full_d = 1'b0;
    end
  end

  // Output drive, registered from the current display value and slot index.
  always_comb begin
    nibble  = '0;
    pattern = '0;
    onehot  = '0;
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    anode_d = AN_OFF;

    case (digit_idx_q)
      2'd0:    nibble = display_q[3:0];
      2'd1:    nibble = display_q[7:4];
      2'd2:    nibble = display_q[11:8];
      default: nibble = display_q[15:12];
    endcase

    if (state_q == SCAN) begin
      pattern = seg_pattern(nibble);
      onehot  = 4'b0001 << digit_idx_q;
`ifdef LEADING_ZERO_BLANK_EN
      // A slot is blank when its digit and every higher digit are zero.
      if ((digit_idx_q == 2'd3 && display_q[15:12] == 4'h0) ||
          (digit_idx_q == 2'd2 && display_q[15:8]  == 8'h00) ||
          (digit_idx_q == 2'd1 && display_q[15:4]  == 12'h000)) begin
        onehot = 4'h0;
      end
`endif
      seg_d   = SEG_ACTIVE_LOW ? ~pattern : pattern;
      anode_d = ANODE_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      display_q      <= '0;
      prescaler_q    <= '0;
      digit_idx_q    <= '0;
      digit_error_q  <= 1'b0;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      anode_q        <= AN_OFF;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      display_q      <= display_d;
      prescaler_q    <= prescaler_d;
      digit_idx_q    <= digit_idx_d;
      digit_error_q  <= digit_error_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      anode_q        <= anode_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign anode       = anode_q;
  assign digit_error = digit_error_q;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// tb/tb_bcd_seven_seg_scanner.sv - self-checking bench for bcd_seven_seg_scanner
module tb_bcd_seven_seg_scanner;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd_number = '0;
  logic        bcd_valid = 1'b0;
  logic        bcd_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic        digit_error;

  bcd_seven_seg_scanner #(
    .REFRESH_DIV(R),
    .SEG_ACTIVE_LOW(1'b1),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bcd_number(bcd_number),
    .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready),
    .seg(seg),
    .dp(dp),
    .anode(anode),
    .digit_error(digit_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since the scan started, the shown token, a one-deep buffer.
  logic [6:0]  pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  bit          m_scan = 0;
  int          m_k = 0;
  int          m_shown = 0;
  int          m_pend[$];
  bit          m_err = 0;
  bit          m_acc = 0;
  logic [12:0] exp_out;
  logic        exp_ready;
  logic        got_ready;

  function automatic bit any_bad(input int v);
    for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 15) > 9) return 1;
    return 0;
  endfunction

  // Drive one cycle, advance the model across the edge, return at the next falling edge.
  task automatic tick(input bit rst, input bit v, input logic [15:0] num);
    bit         pend_empty;
    bit         xfer;
    int         idx;
    int         dig;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    reset      = rst;
    bcd_valid  = v;
    bcd_number = num;
    #1;
    got_ready  = bcd_ready;
    pend_empty = (m_pend.size() == 0);
    exp_ready  = pend_empty;
    @(posedge clk);
    m_acc = 0;
    if (rst) begin
      m_scan = 0;
      m_k    = 0;
      m_pend.delete();
      m_err  = 0;
      exp_out = {7'h7F, 1'b1, 4'hF, 1'b0};
    end else begin
      e_seg = 7'h7F;
      e_an  = 4'hF;
      if (m_scan) begin
        idx   = (m_k / R) % 4;
        dig   = (m_shown >> (4 * idx)) & 15;
        e_seg = ~pat_tab[dig];
        e_an  = ~(4'(1 << idx));
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (m_shown >> (4 * idx)) == 0) e_an = 4'hF;
`endif
      end
      xfer = 0;
      if (!m_scan) begin
        if (!pend_empty) begin
          xfer   = 1;
          m_scan = 1;
          m_k    = 0;
        end
      end else begin
        if ((m_k % (4 * R)) == (4 * R - 1) && !pend_empty) xfer = 1;
        m_k++;
      end
      if (xfer) begin
        m_shown = m_pend.pop_front();
        m_err   = any_bad(m_shown);
      end
      if (v && pend_empty) begin
        m_pend.push_back(int'(num));
        m_acc = 1;
      end
      exp_out = {e_seg, 1'b1, e_an, m_err};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1, 0, 16'h0);
      n_cmp++;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL reset_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
    end
    n_cmp++;
    if (bcd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", bcd_ready);
    end
  endtask

  task automatic test_basic();
    for (int c = 0; c < 3 + 8 * R; c++) begin
      tick(0, c == 0, 16'h1234);
      n_cmp += 2;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL basic_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
      if (got_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL basic_ready c=%0d: got %b want %b", c, got_ready, exp_ready);
      end
      if (c == 2 || c == 2 + R) begin
        n_cmp++;
        if ({anode, seg} !== ((c == 2) ? {4'b1110, 7'h19} : {4'b1101, 7'h30})) begin
          n_bad++;
          $display("FAIL basic_latency c=%0d: got anode %b seg %h", c, anode, seg);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    bit s1 = 0;
    bit s2 = 0;
    logic [15:0] num;
    bit v;
    for (int c = 0; c < 5 * 4 * R; c++) begin
      v = 0;
      num = 16'h0;
      if (c >= 5 && !s1) begin v = 1; num = 16'h0001; end
      else if (s1 && !s2) begin v = 1; num = 16'h0002; end
      tick(0, v, num);
      if (m_acc && num == 16'h0001) s1 = 1;
      if (m_acc && num == 16'h0002) s2 = 1;
      n_cmp += 2;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL mid_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
      if (got_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL mid_ready c=%0d: got %b want %b", c, got_ready, exp_ready);
      end
    end
    n_cmp++;
    if (!s2) begin
      n_bad++;
      $display("FAIL mid_accept_timeout: got %b want 1", s2);
    end
  endtask

  task automatic test_error_digit();
    bit s1 = 0;
    bit s2 = 0;
    logic [15:0] num;
    bit v;
    for (int c = 0; c < 6 * 4 * R; c++) begin
      v = 0;
      num = 16'h0;
      if (!s1) begin v = 1; num = 16'h12A4; end
      else if (c >= 3 * 4 * R && !s2) begin v = 1; num = 16'h5678; end
      tick(0, v, num);
      if (m_acc && num == 16'h12A4) s1 = 1;
      if (m_acc && num == 16'h5678) s2 = 1;
      n_cmp += 2;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL err_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
      if (got_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL err_ready c=%0d: got %b want %b", c, got_ready, exp_ready);
      end
      if (c == 3 * 4 * R - 1 || c == 6 * 4 * R - 1) begin
        n_cmp++;
        if (digit_error !== (c == 3 * 4 * R - 1)) begin
          n_bad++;
          $display("FAIL err_flag c=%0d: got %b want %b", c, digit_error, c == 3 * 4 * R - 1);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    bit s1 = 0;
    bit s2 = 0;
    logic [15:0] num;
    bit v;
    for (int c = 0; c < 6 * 4 * R; c++) begin
      v = 0;
      num = 16'h0;
      if (!s1) begin v = 1; num = 16'h0007; end
      else if (c >= 3 * 4 * R && !s2) begin v = 1; num = 16'h0000; end
      tick(0, v, num);
      if (m_acc && !s1) s1 = 1;
      else if (m_acc) s2 = 1;
      n_cmp += 2;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL lz_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
      if (got_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL lz_ready c=%0d: got %b want %b", c, got_ready, exp_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] num;
    bit v;
    bit r;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) num[4 * i +: 4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) num = num & 16'h00FF;
      v = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 199) == 0);
      tick(r, v, num);
      n_cmp += 2;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL rand_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
      if (got_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, got_ready, exp_ready);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int acc_c = -10;
    bit r;
    bit v;
    for (int c = 0; c < 60; c++) begin
      v = (acc_c < 0);
      r = (c == acc_c + 1);
      tick(r, v, 16'h9876);
      if (m_acc && acc_c < 0) acc_c = c;
      n_cmp += 2;
      if ({seg, dp, anode, digit_error} !== exp_out) begin
        n_bad++;
        $display("FAIL rstmid_out c=%0d: got %h want %h", c, {seg, dp, anode, digit_error}, exp_out);
      end
      if (got_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rstmid_ready c=%0d: got %b want %b", c, got_ready, exp_ready);
      end
      if (r) begin
        n_cmp++;
        if ({seg, dp, anode, digit_error, bcd_ready} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL rstmid_off: got seg %h dp %b anode %h err %b ready %b",
                   seg, dp, anode, digit_error, bcd_ready);
        end
      end
    end
    n_cmp++;
    if (acc_c < 0) begin
      n_bad++;
      $display("FAIL rstmid_accept_timeout: got %0d want >=0", acc_c);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_mid_frame();
    test_error_digit();
    test_leading_zero();
    test_random();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
